pulse_interval_meter: RTL

Downstream consumer of the noise-protected negative-edge detector. Takes its single-cycle `q` strobe and measures the number of clock cycles between consecutive detected pulses. Each interval is presented on a one-entry valid/ready output register. The block also flags pulse loss (timeout) and dropped results (overrun) for the control/status logic.

---
 rtl/pulse_interval_meter.sv | 105 ++++++++++
 1 files changed

// File: rtl/pulse_interval_meter.sv
// Measures clock cycles between consecutive detection strobes and presents
// each interval on a one-entry valid/ready register with timeout/overrun flags.
module pulse_interval_meter #(
    parameter int CNT_W        = 16,
    parameter int MAX_INTERVAL = 1000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             pulse_in,
    input  logic             ready,
    output logic [CNT_W-1:0] interval,
    output logic             valid,
    output logic             timeout,
    output logic             overrun
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_INTERVAL);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic             capture;
    logic             timeout_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        capture   = 1'b0;
        timeout_n = 1'b0;
        if (!en) begin
            state_n = IDLE;
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (pulse_in) begin
                        cnt_n   = ONE;
                        state_n = MEASURE;
                    end
                end
                MEASURE: begin
                    if (pulse_in) begin
                        capture = 1'b1;
                        cnt_n   = ONE;
                    end else if (cnt == MAX_C) begin
                        timeout_n = 1'b1;
                        cnt_n     = '0;
                        state_n   = IDLE;
                    end else begin
                        cnt_n = cnt + ONE;
                    end
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end
            endcase
        end
    end

    // A new result may replace the old one only when the old one leaves this cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            interval <= '0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            timeout <= timeout_n;
            if (capture) begin
                if (!valid || ready) begin
                    interval <= cnt;
                    valid    <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
            if (!en) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule
